// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pkg.sv
// Shared definitions for the registered, elastic inverter pipeline family:
// default geometry and the occupancy-counter width helper.
package gf180mcu_fd_sc_mcu9t5v0__inv_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage.sv
// One valid/data register pair of the elastic inverter pipeline, with the
// combinational ready pass-back to the upstream stage.
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage
    import gf180mcu_fd_sc_mcu9t5v0__inv_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic load;

    // A stage can take a new word when it is empty or its word leaves now.
    assign ready = !valid || down_ready;
    assign load  = up_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else begin
            if (load) begin
                valid <= 1'b1;
            end else if (down_ready) begin
                valid <= 1'b0;
            end
            // Data only moves with a valid word, so an idle X on the input never lands here.
            if (load) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Registered, elastic per-bit inverter: ZN = I ^ POL carried through DEPTH
// valid/ready stages. Define GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN to add the OCC count output.
module gf180mcu_fd_sc_mcu9t5v0__inv_pipe
    import gf180mcu_fd_sc_mcu9t5v0__inv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int RST_VAL = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] POL,
    input  logic             IVALID,
    output logic             IREADY,
    output logic [WIDTH-1:0] ZN,
    output logic             ZVALID,
    input  logic             ZREADY
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] OCC
`endif
);

    localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] pol_word;
    logic             up_vld [DEPTH];
    logic [WIDTH-1:0] up_dat [DEPTH];
    logic             vld    [DEPTH];
    logic [WIDTH-1:0] dat    [DEPTH];
    logic             rdy    [DEPTH+1];

    // Polarity is folded in before stage 0, so later POL changes cannot touch words in flight.
    assign pol_word   = I ^ POL;
    assign rdy[DEPTH] = ZREADY;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_vld[k] = IVALID;
            assign up_dat[k] = pol_word;
        end else begin : g_body
            assign up_vld[k] = vld[k-1];
            assign up_dat[k] = dat[k-1];
        end

        gf180mcu_fd_sc_mcu9t5v0__inv_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_WORD)
        ) u_stage (
            .clk        (CLK),
            .rst_n      (RN),
            .up_valid   (up_vld[k]),
            .up_data    (up_dat[k]),
            .down_ready (rdy[k+1]),
            .ready      (rdy[k]),
            .valid      (vld[k]),
            .data       (dat[k])
        );
    end

    assign IREADY = rdy[0];
    assign ZVALID = vld[DEPTH-1];
    assign ZN     = dat[DEPTH-1];

`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = IVALID && rdy[0];
    assign out_xfer = vld[DEPTH-1] && ZREADY;

    // Simultaneous in and out leaves occupancy unchanged; the handshake keeps it within DEPTH.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            OCC <= '0;
        end else if (in_xfer && !out_xfer) begin
            OCC <= OCC + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            OCC <= OCC - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe.sv
// Self-checking bench for the elastic inverter pipeline (WIDTH=8, DEPTH=2):
// directed steps plus a queue scoreboard of I^POL words.
module tb_gf180mcu_fd_sc_mcu9t5v0__inv_pipe;

    logic       CLK = 1'b0;
    logic       RN;
    logic [7:0] I;
    logic [7:0] POL;
    logic       IVALID;
    logic       ZREADY;
    wire        IREADY;
    wire  [7:0] ZN;
    wire        ZVALID;
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
    wire  [1:0] OCC;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_in     = 0;
    logic [7:0] q[$];

    gf180mcu_fd_sc_mcu9t5v0__inv_pipe #(
        .WIDTH   (8),
        .DEPTH   (2),
        .RST_VAL (0)
    ) dut (
        .CLK    (CLK),
        .RN     (RN),
        .I      (I),
        .POL    (POL),
        .IVALID (IVALID),
        .IREADY (IREADY),
        .ZN     (ZN),
        .ZVALID (ZVALID),
        .ZREADY (ZREADY)
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
        ,
        .OCC    (OCC)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate handshakes just before the edge, then advance to 1 ns past it.
    task automatic tick();
        #1;
        if (RN) begin
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
            check("occ", 32'(OCC), q.size());
`endif
            if (ZVALID && ZREADY) begin
                check("sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("sb_data", 32'(ZN), 32'(q.pop_front()));
            end
            if (IVALID && IREADY) begin
                q.push_back(I ^ POL);
                n_in++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with random inputs
        RN = 1'b0; ZREADY = 1'b0; POL = 8'h00;
        I = 8'($urandom); IVALID = 1'($urandom);
        #1;
        check("rst_zvalid", 32'(ZVALID), 0);
        check("rst_zn", 32'(ZN), 0);
        check("rst_iready", 32'(IREADY), 1);
        for (int c = 0; c < 3; c++) begin
            I = 8'($urandom); IVALID = 1'($urandom); POL = 8'($urandom);
            tick();
        end
        check("rst_hold_zvalid", 32'(ZVALID), 0);
        check("rst_hold_zn", 32'(ZN), 0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
        check("rst_occ", 32'(OCC), 0);
`endif
        RN = 1'b1; IVALID = 1'b0; ZREADY = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check("idle_zvalid", 32'(ZVALID), 0);
        check("idle_iready", 32'(IREADY), 1);

        // Polarity and latency
        I = 8'hA5; POL = 8'hFF; IVALID = 1'b1;
        tick();
        POL = 8'h0F;
        tick();
        IVALID = 1'b0; I = 8'hxx; POL = 8'hxx;
        #1;
        check("pol_zvalid_0", 32'(ZVALID), 1);
        check("pol_zn_0", 32'(ZN), 32'h5A);
        tick();
        check("pol_zvalid_1", 32'(ZVALID), 1);
        check("pol_zn_1", 32'(ZN), 32'hAA);
        tick();
        check("pol_zvalid_end", 32'(ZVALID), 0);

        // Back-pressure, then full pipe with simultaneous in/out
        ZREADY = 1'b0; POL = 8'h00; IVALID = 1'b1; I = 8'h01;
        #1 check("bp_iready_1", 32'(IREADY), 1);
        tick();
        I = 8'h02;
        #1 check("bp_iready_2", 32'(IREADY), 1);
        tick();
        I = 8'h03;
        #1;
        check("bp_iready_full", 32'(IREADY), 0);
        check("bp_zvalid", 32'(ZVALID), 1);
        check("bp_zn_hold_a", 32'(ZN), 32'h01);
        tick();
        check("bp_zn_hold_b", 32'(ZN), 32'h01);
        check("bp_zvalid_hold", 32'(ZVALID), 1);
        tick();
        ZREADY = 1'b1;
        #1;
        check("full_iready", 32'(IREADY), 1);
        check("full_zn_01", 32'(ZN), 32'h01);
        tick();
`ifdef GF180MCU_FD_SC_MCU9T5V0__INV_PIPE_OCC_EN
        check("full_occ_after", 32'(OCC), 2);
`endif
        IVALID = 1'b0;
        check("drain_zn_02", 32'(ZN), 32'h02);
        tick();
        check("drain_zn_03", 32'(ZN), 32'h03);
        tick();
        check("drain_zvalid_end", 32'(ZVALID), 0);
        check("drain_sb_empty", q.size(), 0);

        // Reset mid-flight
        ZREADY = 1'b0; IVALID = 1'b1; I = 8'h11;
        tick();
        I = 8'h22;
        tick();
        IVALID = 1'b0;
        #2;
        RN = 1'b0;
        #1;
        check("mid_rst_zvalid", 32'(ZVALID), 0);
        check("mid_rst_zn", 32'(ZN), 0);
        check("mid_rst_iready", 32'(IREADY), 1);
        RN = 1'b1;
        q.delete();
        ZREADY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mid_rst_no_ghost", 32'(ZVALID), 0);
        end

        // Random throughput with random back-pressure
        begin
            int base;
            base = n_in;
            for (int c = 0; c < 3000 && (n_in - base) < 100; c++) begin
                I = 8'($urandom); POL = 8'($urandom);
                IVALID = ($urandom_range(0, 9) < 7);
                ZREADY = 1'($urandom);
                tick();
            end
            check("rand_words_accepted", n_in - base, 100);
        end
        IVALID = 1'b0; ZREADY = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) tick();
        check("rand_sb_empty", q.size(), 0);
        #1 check("rand_zvalid_end", 32'(ZVALID), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
